// File: rtl/cfg_frame_tx.sv
`timescale 1ns/1ps
// cfg_frame_tx
// Serial transmitter for the tile configuration scan port.
//
// Accepts one command at a time over a valid/ready handshake. It then does
// one of the following:
//   - WRITE or LOAD: shifts a 39-bit SRAM-control frame MSB-first onto
//     cfg_scan_in with cfg_scan_en high, then holds the chain idle for
//     HOLD_CYCLES so the tile can capture the frame.
//   - LUT_STROBE: pulses cfg_lut_we for one cycle.
//   - Reserved opcode: fails straight away.
// Every command finishes with a one-cycle resp_valid pulse. The bits that
// return on cfg_scan_out during a shift hold the previous chain contents.
// They are collected into resp_rdback.
//
// Ports
//   cfg_clk, cfg_rst_n       : clock and synchronous active-low reset
//   cmd_valid / cmd_ready    : command handshake
//   cmd_op                   : 00 WRITE, 01 LOAD, 10 LUT_STROBE, 11 reserved
//   cmd_addr, cmd_data       : word address and config word
//   cfg_scan_en, cfg_scan_in : scan shift enable and serial data out
//   cfg_lut_we               : LUT write strobe
//   cfg_scan_out             : serial data returned from the end of the chain
//   resp_valid, resp_err     : completion pulse and error qualifier
//   resp_rdback              : frame shifted out during the last shift
module cfg_frame_tx #(
  parameter int FRAME_BITS  = 39,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  cfg_clk,
  input  logic                  cfg_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_data,
  output logic                  cfg_scan_en,
  output logic                  cfg_scan_in,
  output logic                  cfg_lut_we,
  input  logic                  cfg_scan_out,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [FRAME_BITS-1:0] resp_rdback
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STROBE = 2'b10;

  localparam logic [5:0] SHIFT_LAST = 6'(FRAME_BITS - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_STROBE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] rdback_q, rdback_d;
  logic [5:0]            shift_cnt_q, shift_cnt_d;
  logic [3:0]            hold_cnt_q, hold_cnt_d;
  logic                  err_q, err_d;
  // live_q keeps cmd_ready low while reset is asserted. The FSM is already
  // in IDLE during reset, but it must not report ready until one cycle
  // after reset is released.
  logic                  live_q;

  assign resp_rdback = rdback_q;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rdback_d    = rdback_q;
    shift_cnt_d = shift_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    err_d       = err_q;
    cmd_ready   = 1'b0;
    cfg_scan_en = 1'b0;
    cfg_scan_in = 1'b0;
    cfg_lut_we  = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          err_d       = 1'b0;
          shift_cnt_d = '0;
          hold_cnt_d  = '0;
          case (cmd_op)
            OP_WRITE: begin
              frame_d = FRAME_BITS'({cmd_data, 3'b001, cmd_addr});
              state_d = S_SHIFT;
            end
            OP_LOAD: begin
              frame_d = FRAME_BITS'({{DATA_W{1'b0}}, 3'b100, cmd_addr});
              state_d = S_SHIFT;
            end
            OP_STROBE: state_d = S_STROBE;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_SHIFT: begin
        // The frame register shifts left, so its MSB is always the bit
        // currently on the wire. On shift cycle k this is frame[38-k].
        cfg_scan_en = 1'b1;
        cfg_scan_in = frame_q[FRAME_BITS-1];
        frame_d     = {frame_q[FRAME_BITS-2:0], 1'b0};
        rdback_d    = {rdback_q[FRAME_BITS-2:0], cfg_scan_out};
        if (shift_cnt_q == SHIFT_LAST) begin
          state_d = S_HOLD;
        end else begin
          shift_cnt_d = shift_cnt_q + 6'd1;
        end
      end

      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_DONE;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      S_STROBE: begin
        cfg_lut_we = 1'b1;
        state_d    = S_DONE;
      end

      S_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cfg_clk) begin
    if (!cfg_rst_n) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      rdback_q    <= '0;
      shift_cnt_q <= '0;
      hold_cnt_q  <= '0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rdback_q    <= rdback_d;
      shift_cnt_q <= shift_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      err_q       <= err_d;
      live_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cfg_frame_tx.sv
`timescale 1ns/1ps
// Directed bench for cfg_frame_tx. A 39-bit model of the tile scan chain
// sits in a loop between cfg_scan_in and cfg_scan_out.
module tb_cfg_frame_tx;

  logic        cfg_clk   = 1'b0;
  logic        cfg_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op    = 2'b00;
  logic [3:0]  cmd_addr  = 4'h0;
  logic [31:0] cmd_data  = 32'h0;
  logic        cmd_ready, cfg_scan_en, cfg_scan_in, cfg_lut_we, cfg_scan_out;
  logic        resp_valid, resp_err;
  logic [38:0] resp_rdback;

  logic [38:0] chain_q = '0;
  int errors = 0;
  int checks = 0;
  int viol   = 0;

  // Observations from the most recent run_cmd
  logic        o_ready_pre, o_ready_post, o_ready_after, o_resp_err;
  int          o_en_cnt, o_en_first, o_lut_cnt, o_lut_first, o_resp_cyc;
  logic [38:0] o_stream;

  localparam logic [38:0] FRAME_W = {32'hDEADBEEF, 7'h13};
  localparam logic [38:0] FRAME_L = {32'h00000000, 7'h43};

  cfg_frame_tx dut (
    .cfg_clk      (cfg_clk),
    .cfg_rst_n    (cfg_rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cfg_scan_en  (cfg_scan_en),
    .cfg_scan_in  (cfg_scan_in),
    .cfg_lut_we   (cfg_lut_we),
    .cfg_scan_out (cfg_scan_out),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdback  (resp_rdback)
  );

  always #5 cfg_clk = ~cfg_clk;

  assign cfg_scan_out = chain_q[38];
  always @(posedge cfg_clk) if (cfg_scan_en) chain_q <= {chain_q[37:0], cfg_scan_in};

  always @(negedge cfg_clk) begin
    if (cfg_scan_en && cfg_lut_we) viol++;
    if (resp_err && !resp_valid) viol++;
  end

  // Issues one command and records what the DUT does. The cycle after the
  // accept edge is cycle 1.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data);
    @(negedge cfg_clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    o_ready_pre = cmd_ready;
    o_en_cnt = 0; o_en_first = 0; o_lut_cnt = 0; o_lut_first = 0;
    o_resp_cyc = 0; o_resp_err = 1'b0; o_stream = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge cfg_clk);
      if (cyc == 1) begin
        o_ready_post = cmd_ready;
        cmd_valid = 1'b0; cmd_data = ~data; cmd_addr = ~addr; cmd_op = 2'b11;
      end
      if (cfg_scan_en) begin
        if (o_en_cnt == 0) o_en_first = cyc;
        o_en_cnt++;
        o_stream = {o_stream[37:0], cfg_scan_in};
      end
      if (cfg_lut_we) begin
        if (o_lut_cnt == 0) o_lut_first = cyc;
        o_lut_cnt++;
      end
      if (resp_valid) begin
        o_resp_cyc = cyc; o_resp_err = resp_err;
        break;
      end
    end
    @(negedge cfg_clk);
    o_ready_after = cmd_ready;
    $display("cmd op=%0d addr=%0h data=%08h: scan_en=%0d lut_we=%0d resp@%0d err=%0b rdback=%010h",
             op, addr, data, o_en_cnt, o_lut_cnt, o_resp_cyc, o_resp_err, resp_rdback);
  endtask

  task automatic test_reset();
    cfg_rst_n = 1'b0;
    repeat (3) @(posedge cfg_clk);
    @(negedge cfg_clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    checks++; if (cfg_scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en: got %b expected 0", cfg_scan_en); end
    checks++; if (cfg_scan_in !== 1'b0) begin errors++; $display("FAIL reset_scan_in: got %b expected 0", cfg_scan_in); end
    checks++; if (cfg_lut_we !== 1'b0) begin errors++; $display("FAIL reset_lut_we: got %b expected 0", cfg_lut_we); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdback !== 39'h0) begin errors++; $display("FAIL reset_rdback: got %h expected 0", resp_rdback); end
    cfg_rst_n = 1'b1;
    @(negedge cfg_clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write();
    run_cmd(2'b00, 4'h3, 32'hDEADBEEF);
    checks++; if (o_ready_pre !== 1'b1) begin errors++; $display("FAIL write_ready_pre: got %b expected 1", o_ready_pre); end
    checks++; if (o_ready_post !== 1'b0) begin errors++; $display("FAIL write_ready_post: got %b expected 0", o_ready_post); end
    checks++; if (o_en_cnt != 39) begin errors++; $display("FAIL write_en_cycles: got %0d expected 39", o_en_cnt); end
    checks++; if (o_en_first != 1) begin errors++; $display("FAIL write_en_first: got %0d expected 1", o_en_first); end
    checks++; if (o_stream !== FRAME_W) begin errors++; $display("FAIL write_stream: got %h expected %h", o_stream, FRAME_W); end
    checks++; if (o_resp_cyc != 42) begin errors++; $display("FAIL write_latency: got %0d expected 42", o_resp_cyc); end
    checks++; if (o_resp_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", o_resp_err); end
    checks++; if (resp_rdback !== 39'h0) begin errors++; $display("FAIL write_rdback: got %h expected 0", resp_rdback); end
    checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL write_ready_after: got %b expected 1", o_ready_after); end
  endtask

  task automatic test_load_readback();
    run_cmd(2'b01, 4'h3, 32'hFFFFFFFF);
    checks++; if (o_stream !== FRAME_L) begin errors++; $display("FAIL load_stream: got %h expected %h", o_stream, FRAME_L); end
    checks++; if (resp_rdback !== FRAME_W) begin errors++; $display("FAIL load_rdback: got %h expected %h", resp_rdback, FRAME_W); end
    checks++; if (chain_q !== FRAME_L) begin errors++; $display("FAIL load_chain: got %h expected %h", chain_q, FRAME_L); end
    checks++; if (o_resp_cyc != 42) begin errors++; $display("FAIL load_latency: got %0d expected 42", o_resp_cyc); end
  endtask

  task automatic test_lut_strobe();
    run_cmd(2'b10, 4'h7, 32'h12345678);
    checks++; if (o_lut_cnt != 1) begin errors++; $display("FAIL lut_cycles: got %0d expected 1", o_lut_cnt); end
    checks++; if (o_lut_first != 1) begin errors++; $display("FAIL lut_first: got %0d expected 1", o_lut_first); end
    checks++; if (o_en_cnt != 0) begin errors++; $display("FAIL lut_scan_en: got %0d expected 0", o_en_cnt); end
    checks++; if (o_resp_cyc != 2) begin errors++; $display("FAIL lut_latency: got %0d expected 2", o_resp_cyc); end
    checks++; if (o_resp_err !== 1'b0) begin errors++; $display("FAIL lut_err: got %b expected 0", o_resp_err); end
    checks++; if (resp_rdback !== FRAME_W) begin errors++; $display("FAIL lut_rdback: got %h expected %h", resp_rdback, FRAME_W); end
  endtask

  task automatic test_reserved();
    run_cmd(2'b11, 4'hA, 32'hCAFEF00D);
    checks++; if (o_en_cnt != 0) begin errors++; $display("FAIL rsv_scan_en: got %0d expected 0", o_en_cnt); end
    checks++; if (o_lut_cnt != 0) begin errors++; $display("FAIL rsv_lut_we: got %0d expected 0", o_lut_cnt); end
    checks++; if (o_resp_cyc != 1) begin errors++; $display("FAIL rsv_latency: got %0d expected 1", o_resp_cyc); end
    checks++; if (o_resp_err !== 1'b1) begin errors++; $display("FAIL rsv_err: got %b expected 1", o_resp_err); end
    checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL rsv_ready_after: got %b expected 1", o_ready_after); end
  endtask

  task automatic test_reset_abort();
    int n_resp = 0;
    @(negedge cfg_clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'h5; cmd_data = 32'h12345678;
    @(negedge cfg_clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge cfg_clk);
    // This is shift cycle 20.
    checks++; if (cfg_scan_en !== 1'b1) begin errors++; $display("FAIL abort_mid_shift: got %b expected 1", cfg_scan_en); end
    cfg_rst_n = 1'b0;
    @(negedge cfg_clk);
    checks++; if (cfg_scan_en !== 1'b0) begin errors++; $display("FAIL abort_scan_en: got %b expected 0", cfg_scan_en); end
    checks++; if (resp_rdback !== 39'h0) begin errors++; $display("FAIL abort_rdback: got %h expected 0", resp_rdback); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", cmd_ready); end
    if (resp_valid) n_resp++;
    cfg_rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge cfg_clk);
      if (resp_valid) n_resp++;
    end
    checks++; if (n_resp != 0) begin errors++; $display("FAIL abort_no_resp: got %0d expected 0", n_resp); end
    run_cmd(2'b00, 4'h9, 32'hA5A50F0F);
    checks++; if (o_stream !== {32'hA5A50F0F, 7'h19}) begin errors++; $display("FAIL abort_next_stream: got %h expected %h", o_stream, {32'hA5A50F0F, 7'h19}); end
    checks++; if (o_resp_cyc != 42) begin errors++; $display("FAIL abort_next_latency: got %0d expected 42", o_resp_cyc); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [3];
    logic [31:0] dtab [3];
    int n_acc = 0, runs = 0, run_len = 0, gap = 0, bad_run = 0, bad_gap = 0;
    bit prev_en = 0, had_run = 0, acc_pending = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    dtab[0] = 32'h11111111; dtab[1] = 32'h22222222; dtab[2] = 32'h33333333;
    @(negedge cfg_clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'h1; cmd_data = dtab[0];
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge cfg_clk);
      if (acc_pending) begin
        acc_pending = 0;
        if (n_acc < 3) begin cmd_addr = 4'(n_acc + 1); cmd_data = dtab[n_acc]; end
        else cmd_valid = 1'b0;
      end
      if (cfg_scan_en) begin
        if (!prev_en && had_run && gap != 4) bad_gap++;
        run_len++; gap = 0;
      end else begin
        if (prev_en) begin
          runs++; had_run = 1;
          if (run_len != 39) bad_run++;
          run_len = 0;
        end
        gap++;
      end
      prev_en = cfg_scan_en;
      if (cmd_valid && cmd_ready) begin
        if (n_acc < 3) acc_cyc[n_acc] = cyc;
        n_acc++; acc_pending = 1;
      end
    end
    cmd_valid = 1'b0;
    $display("b2b accepts=%0d at %0d,%0d,%0d runs=%0d", n_acc, acc_cyc[0], acc_cyc[1], acc_cyc[2], runs);
    checks++; if (n_acc != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", n_acc); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 43) begin errors++; $display("FAIL b2b_spacing1: got %0d expected 43", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (acc_cyc[2] - acc_cyc[1] != 43) begin errors++; $display("FAIL b2b_spacing2: got %0d expected 43", acc_cyc[2] - acc_cyc[1]); end
    checks++; if (runs != 3) begin errors++; $display("FAIL b2b_runs: got %0d expected 3", runs); end
    checks++; if (bad_run != 0) begin errors++; $display("FAIL b2b_run_len: got %0d bad expected 0", bad_run); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d bad expected 0", bad_gap); end
    checks++; if (resp_rdback !== {32'h22222222, 7'h12}) begin errors++; $display("FAIL b2b_rdback: got %h expected %h", resp_rdback, {32'h22222222, 7'h12}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_load_readback();
    test_lut_strobe();
    test_reserved();
    test_reset_abort();
    test_back_to_back();
    checks++; if (viol != 0) begin errors++; $display("FAIL invariants: got %0d violations expected 0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
